// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed driver for common-anode 7-segment hex digits.
// One digit is enabled per slot of SCAN_DIV cycles, and the first cycle of every slot
// is dead time with everything off. All display outputs come straight from flops.
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [4*NUM_DIGITS-1:0] val_reg;
  logic [NUM_DIGITS-1:0]   dp_reg;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;

  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic                    frame_next;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   sel_onehot;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble; all 16 codes listed.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Per-digit nibble view, one-hot digit decode and leading-zero flags.
  // Digit i is a leading zero when it and every more significant nibble are zero;
  // digit 0 is never blanked so a zero value still shows a single "0".
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]        = val_reg[4*gi +: 4];
      assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = ~|val_reg[4*NUM_DIGITS-1:4*gi];
      end
    end
  endgenerate

  // Slot counter / digit index advance and next output pattern from pre-edge state.
  always_comb begin
    cnt_next   = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    idx_next   = idx_reg;
    if (cnt_reg == CNT_LAST) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
    seg_next   = SEG_OFF;
    dp_next    = 1'b1;
    sel_next   = '1;
    frame_next = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
    if (cnt_reg != '0) begin
      sel_next = ~sel_onehot;
      seg_next = (blank_lz && lz_blank[idx_reg]) ? SEG_OFF : enc(nib[idx_reg]);
      dp_next  = ~dp_reg[idx_reg];
    end
  end

  // Display value capture and scan position; reset overrides a coincident load.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_reg <= '0;
      dp_reg  <= '0;
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      if (load) begin
        val_reg <= value;
        dp_reg  <= dp_in;
      end
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // Registered pin drivers so the board sees glitch-free segment and digit lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n       <= SEG_OFF;
      dp_n        <= 1'b1;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
    end else begin
      seg_n       <= seg_next;
      dp_n        <= dp_next;
      digit_sel_n <= sel_next;
      frame_done  <= frame_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (4 digits, 4 cycles per slot).
// Expected pin values are pushed when each cycle's inputs are driven and popped after the edge.
module tb_hex_display_scanner;

  localparam int N = 4;
  localparam int D = 4;

  logic           clk;
  logic           reset;
  logic           load;
  logic [4*N-1:0] value;
  logic [N-1:0]   dp_in;
  logic           blank_lz;
  logic [6:0]     seg_n;
  logic           dp_n;
  logic [N-1:0]   digit_sel_n;
  logic           frame_done;

  hex_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .digit_sel_n (digit_sel_n),
    .frame_done  (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] sel;
    logic         fd;
  } exp_t;

  exp_t sb[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model of the display state
  logic [4*N-1:0] m_val;
  logic [N-1:0]   m_dp;
  int             m_cnt;
  int             m_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_count = 0;
  logic [7:0] seen_seg [N];
  logic [1:0] seen_dp  [N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic clear_seen();
    for (int d = 0; d < N; d++) begin
      seen_seg[d] = 8'hFF;
      seen_dp[d]  = 2'b11;
    end
  endtask

  // One clock: predict, advance model, clock DUT, compare.
  task automatic step();
    exp_t e;
    logic [4*N-1:0] upper;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.sel = '1;
    e.fd  = 1'b0;
    if (!reset) begin
      e.fd = (m_cnt == D - 1) && (m_idx == N - 1);
      if (m_cnt != 0) begin
        upper = m_val >> (4 * m_idx);
        e.sel = ~(N'(1) << m_idx);
        e.dp  = ~m_dp[m_idx];
        if (blank_lz && m_idx > 0 && upper == '0)
          e.seg = 7'h7F;
        else
          e.seg = seg_tab[(m_val >> (4 * m_idx)) & 4'hF];
      end
    end
    sb.push_back(e);
    if (reset) begin
      m_val = '0;
      m_dp  = '0;
      m_cnt = 0;
      m_idx = 0;
    end else begin
      if (load) begin
        m_val = value;
        m_dp  = dp_in;
      end
      if (m_cnt == D - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("seg_n", 32'(seg_n), 32'(e.seg));
      check_eq("dp_n", 32'(dp_n), 32'(e.dp));
      check_eq("digit_sel_n", 32'(digit_sel_n), 32'(e.sel));
      check_eq("frame_done", 32'(frame_done), 32'(e.fd));
    end
    check_eq("onecold", 32'($countones(~digit_sel_n) <= 1), 32'd1);
    if (frame_done) fd_count++;
    for (int d = 0; d < N; d++) begin
      if (!digit_sel_n[d]) begin
        seen_seg[d] = {1'b0, seg_n};
        seen_dp[d]  = {1'b0, dp_n};
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    $display("load value=%h dp=%b blank_lz=%b", v, dp, blank_lz);
    step();
    load  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b1;
    m_val = '0; m_dp = '0; m_cnt = 0; m_idx = 0;
    clear_seen();
    run(2);
    check_eq("rst_seg", 32'(seg_n), 32'h7F);
    check_eq("rst_sel", 32'(digit_sel_n), 32'hF);
    reset = 1'b0;

    // idle after reset: single "0" with blanking, all zeros without
    clear_seen();
    run(16);
    check_eq("idle_lz_d0", 32'(seen_seg[0]), 32'h40);
    check_eq("idle_lz_d1", 32'(seen_seg[1]), 32'h7F);
    check_eq("idle_lz_d3", 32'(seen_seg[3]), 32'h7F);
    blank_lz = 1'b0;
    run(4);
    clear_seen();
    run(16);
    check_eq("idle_d2", 32'(seen_seg[2]), 32'h40);
    check_eq("idle_d3", 32'(seen_seg[3]), 32'h40);

    // 1A2F without blanking, two frames
    do_load(16'h1A2F, 4'b0000);
    run(3);
    clear_seen();
    fd_count = 0;
    run(32);
    check_eq("1a2f_d0", 32'(seen_seg[0]), 32'h0E);
    check_eq("1a2f_d1", 32'(seen_seg[1]), 32'h24);
    check_eq("1a2f_d2", 32'(seen_seg[2]), 32'h08);
    check_eq("1a2f_d3", 32'(seen_seg[3]), 32'h79);
    check_eq("frame_cnt", 32'(fd_count), 32'd2);

    // 00C0 with blanking, then blanking released
    blank_lz = 1'b1;
    do_load(16'h00C0, 4'b0000);
    run(3);
    clear_seen();
    run(16);
    check_eq("00c0_d0", 32'(seen_seg[0]), 32'h40);
    check_eq("00c0_d1", 32'(seen_seg[1]), 32'h46);
    check_eq("00c0_d2", 32'(seen_seg[2]), 32'h7F);
    check_eq("00c0_d3", 32'(seen_seg[3]), 32'h7F);
    blank_lz = 1'b0;
    run(4);
    clear_seen();
    run(16);
    check_eq("00c0_nolz_d2", 32'(seen_seg[2]), 32'h40);
    check_eq("00c0_nolz_d3", 32'(seen_seg[3]), 32'h40);

    // decimal point on a blanked digit
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0100);
    run(3);
    clear_seen();
    run(16);
    check_eq("dp_d2_seg", 32'(seen_seg[2]), 32'h7F);
    check_eq("dp_d2_dp", 32'(seen_dp[2]), 32'h0);
    check_eq("dp_d0_dp", 32'(seen_dp[0]), 32'h1);
    check_eq("dp_d1_dp", 32'(seen_dp[1]), 32'h1);
    check_eq("dp_d3_dp", 32'(seen_dp[3]), 32'h1);
    check_eq("dp_d0_seg", 32'(seen_seg[0]), 32'h12);

    // all sixteen codes
    blank_lz = 1'b0;
    do_load(16'h3210, 4'b1010); run(16);
    do_load(16'h7654, 4'b0101); run(16);
    do_load(16'hBA98, 4'b0000); run(16);
    do_load(16'hFEDC, 4'b1111); run(16);

    // load and reset on the same edge: reset wins
    value = 16'hFFFF; dp_in = 4'hF; load = 1'b1; reset = 1'b1;
    $display("load+reset value=%h", value);
    step();
    load = 1'b0; reset = 1'b0;
    check_eq("lr_seg", 32'(seg_n), 32'h7F);
    check_eq("lr_sel", 32'(digit_sel_n), 32'hF);
    clear_seen();
    run(16);
    check_eq("lr_d1", 32'(seen_seg[1]), 32'h40);
    check_eq("lr_d3", 32'(seen_seg[3]), 32'h40);
    check_eq("lr_dp3", 32'(seen_dp[3]), 32'h1);

    // reset mid-slot at digit 2, cycle 2
    do_load(16'h4321, 4'b0000);
    for (int k = 0; k < 32 && !(m_idx == 2 && m_cnt == 2); k++) step();
    check_eq("mid_reach", 32'(m_idx == 2 && m_cnt == 2), 32'd1);
    reset = 1'b1;
    $display("reset mid-slot");
    step();
    reset = 1'b0;
    check_eq("mid_sel", 32'(digit_sel_n), 32'hF);
    check_eq("mid_seg", 32'(seg_n), 32'h7F);
    check_eq("mid_dp", 32'(dp_n), 32'h1);
    run(2);
    check_eq("mid_resume", 32'(digit_sel_n), 32'hE);

    // random loads and blanking
    for (int k = 0; k < 80; k++) begin
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        do_load(16'($urandom), 4'($urandom));
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
